regfile_mp: RTL and testbench

//  Parametrised multi-port general register file for the ID stage. It has NR combinational

---
 rtl/regfile_mp_pkg.sv | 20 ++
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp_scoreboard.sv | 56 +++++
 rtl/regfile_mp.sv | 93 +++++++++
 tb/tb_regfile_mp.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file.
// Build option: define REGFILE_CLEAR_EN to have reset clear the register array.
package regfile_mp_pkg;

    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

    localparam int unsigned DwDefault = 32;
    localparam int unsigned AwDefault = 5;
    localparam int unsigned NrDefault = 2;

    // Which source a read port selects.
    typedef enum logic [1:0] {
        SrcZero  = 2'd0,
        SrcWb1   = 2'd1,
        SrcWb0   = 2'd2,
        SrcArray = 2'd3
    } rd_src_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Write, read, issue and scoreboard signals of the register file.
interface regfile_mp_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned NR = 2
);
    logic             we0;
    logic [AW-1:0]    waddr0;
    logic [DW-1:0]    wdata0;
    logic             we1;
    logic [AW-1:0]    waddr1;
    logic [DW-1:0]    wdata1;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic [AW:0]      busy_cnt;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, iss_valid, iss_addr,
        input  rdata, rbusy, busy_cnt
    );

    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, iss_valid, iss_addr,
        output rdata, rbusy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running busy count.
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int unsigned AW    = 5,
    parameter int unsigned Depth = 1 << AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid_i,
    input  logic [AW-1:0]    iss_addr_i,
    input  logic             we0_i,
    input  logic [AW-1:0]    waddr0_i,
    input  logic             we1_i,
    input  logic [AW-1:0]    waddr1_i,
    output logic [Depth-1:0] busy_o,
    output logic [Depth-1:0] clr_o,
    output logic [AW:0]      busy_cnt_o
);
    logic [Depth-1:0] busy_q, busy_d, set_v, clr_v, rise_v, fall_v;
    logic [AW:0]      cnt_q, cnt_d, n_rise, n_fall;

    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int r = 1; r < int'(Depth); r++) begin
            set_v[r] = iss_valid_i && (iss_addr_i == AW'(r));
            clr_v[r] = (we0_i && (waddr0_i == AW'(r))) || (we1_i && (waddr1_i == AW'(r)));
        end
        // A new producer issued in the same cycle as a writeback keeps the register busy.
        busy_d = set_v | (busy_q & ~clr_v);
        rise_v = busy_d & ~busy_q;
        fall_v = busy_q & ~busy_d;
        n_rise = '0;
        n_fall = '0;
        for (int r = 0; r < int'(Depth); r++) begin
            n_rise = n_rise + (AW + 1)'(rise_v[r]);
            n_fall = n_fall + (AW + 1)'(fall_v[r]);
        end
        cnt_d = cnt_q + n_rise - n_fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign clr_o      = clr_v;
    assign busy_cnt_o = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational read ports with writeback bypass, two write
// ports (WB1 wins on conflict), and a RAW scoreboard. Option: REGFILE_CLEAR_EN.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DW = DwDefault,
    parameter int unsigned AW = AwDefault,
    parameter int unsigned NR = NrDefault
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int unsigned Depth = 1 << AW;

    logic [DW-1:0]    regs_q [Depth];
    logic             wr0, wr1;
    logic [Depth-1:0] busy, clr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;

    assign wr1 = bus.we1 && (bus.waddr1 != '0);
    assign wr0 = bus.we0 && (bus.waddr0 != '0) && !(wr1 && (bus.waddr0 == bus.waddr1));

`ifdef REGFILE_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            for (int i = 0; i < int'(Depth); i++) regs_q[i] <= '0;
        end else begin
            if (wr0) regs_q[bus.waddr0] <= bus.wdata0;
            if (wr1) regs_q[bus.waddr1] <= bus.wdata1;
        end
    end
`else
    // Array is not reset; r0 is never written and masked by the read mux.
    always_ff @(posedge clk) begin
        if (rst_n == RstDisable) begin
            if (wr0) regs_q[bus.waddr0] <= bus.wdata0;
            if (wr1) regs_q[bus.waddr1] <= bus.wdata1;
        end
    end
`endif

    regfile_mp_scoreboard #(
        .AW    (AW),
        .Depth (Depth)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid_i (bus.iss_valid),
        .iss_addr_i  (bus.iss_addr),
        .we0_i       (bus.we0),
        .waddr0_i    (bus.waddr0),
        .we1_i       (bus.we1),
        .waddr1_i    (bus.waddr1),
        .busy_o      (busy),
        .clr_o       (clr),
        .busy_cnt_o  (bus.busy_cnt)
    );

    for (genvar i = 0; i < int'(NR); i++) begin : g_rd
        logic [AW-1:0] ra;
        rd_src_e       src;
        logic [DW-1:0] rd;

        assign ra = bus.raddr[i*AW +: AW];

        always_comb begin
            if (rst_n == RstEnable || !bus.re[i] || ra == '0) src = SrcZero;
            else if (bus.we1 && bus.waddr1 == ra)              src = SrcWb1;
            else if (bus.we0 && bus.waddr0 == ra)              src = SrcWb0;
            else                                               src = SrcArray;
        end

        always_comb begin
            rd = '0;
            unique case (src)
                SrcZero:  rd = '0;
                SrcWb1:   rd = bus.wdata1;
                SrcWb0:   rd = bus.wdata0;
                SrcArray: rd = regs_q[ra];
                default:  rd = '0;
            endcase
        end

        assign rdata[i*DW +: DW] = rd;
        // A same-cycle writeback resolves the hazard through the bypass.
        assign rbusy[i] = (src != SrcZero) && busy[ra] && !clr[ra];
    end

    assign bus.rdata = rdata;
    assign bus.rbusy = rbusy;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR)) bus ();

    regfile_mp #(.DW(DW), .AW(AW), .NR(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_wb();
        bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
        bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.iss_valid = 1'b0; bus.iss_addr = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.raddr = {a1, a0};
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle_wb();
        bus.re = 2'b11;
        set_ra(5'd3, 5'd3);

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", 64'(bus.rdata), 64'h0);
        chk("rst_rbusy", 64'(bus.rbusy), 64'h0);
        chk("rst_cnt", 64'(bus.busy_cnt), 64'h0);

        // Write r5 via port 0, bypass then array
        @(negedge clk);
        rst_n = 1'b1;
        bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEADBEEF;
        set_ra(5'd5, 5'd3);
        #1;
        chk("wr_bypass", 64'(bus.rdata[31:0]), 64'hDEADBEEF);
        @(negedge clk);
        idle_wb();
        set_ra(5'd5, 5'd5);
        #1;
        chk("wr_array_p0", 64'(bus.rdata[31:0]), 64'hDEADBEEF);
        chk("wr_array_p1", 64'(bus.rdata[63:32]), 64'hDEADBEEF);
        chk("wr_rbusy", 64'(bus.rbusy), 64'h0);
        bus.re = 2'b01;
        #1;
        chk("re_off_p1", 64'(bus.rdata[63:32]), 64'h0);
        bus.re = 2'b11;

        // Dual write to r7, port 1 wins
        @(negedge clk);
        bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'd1;
        bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'd2;
        set_ra(5'd7, 5'd7);
        #1;
        chk("dual_bypass", 64'(bus.rdata), {32'd2, 32'd2});
        @(negedge clk);
        idle_wb();
        #1;
        chk("dual_array", 64'(bus.rdata), {32'd2, 32'd2});

        // r0: write and issue both ignored
        @(negedge clk);
        bus.we1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 32'hFFFF_FFFF;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
        set_ra(5'd0, 5'd0);
        #1;
        chk("r0_rdata", 64'(bus.rdata), 64'h0);
        chk("r0_rbusy", 64'(bus.rbusy), 64'h0);
        @(negedge clk);
        idle_wb();
        #1;
        chk("r0_cnt", 64'(bus.busy_cnt), 64'h0);
        chk("r0_rdata_after", 64'(bus.rdata), 64'h0);

        // Scoreboard on r9
        @(negedge clk);
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        set_ra(5'd9, 5'd5);
        @(negedge clk);
        idle_wb();
        #1;
        chk("sb_rbusy", 64'(bus.rbusy), 64'b01);
        chk("sb_cnt1", 64'(bus.busy_cnt), 64'd1);
        @(negedge clk);
        bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h99;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        #1;
        chk("sb_wb_rbusy", 64'(bus.rbusy), 64'b00);
        chk("sb_wb_bypass", 64'(bus.rdata[31:0]), 64'h99);
        @(negedge clk);
        idle_wb();
        #1;
        chk("sb_reissue_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("sb_reissue_rbusy", 64'(bus.rbusy), 64'b01);
        @(negedge clk);
        bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'hAA;
        @(negedge clk);
        idle_wb();
        #1;
        chk("sb_clear_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("sb_clear_rbusy", 64'(bus.rbusy), 64'b00);
        chk("sb_clear_data", 64'(bus.rdata[31:0]), 64'hAA);

        // Two clears in one cycle
        @(negedge clk);
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd10;
        @(negedge clk);
        bus.iss_addr = 5'd11;
        @(negedge clk);
        idle_wb();
        #1;
        chk("sb_two_cnt", 64'(bus.busy_cnt), 64'd2);
        @(negedge clk);
        bus.we0 = 1'b1; bus.waddr0 = 5'd10; bus.wdata0 = 32'h10;
        bus.we1 = 1'b1; bus.waddr1 = 5'd11; bus.wdata1 = 32'h11;
        @(negedge clk);
        idle_wb();
        #1;
        chk("sb_dual_clear_cnt", 64'(bus.busy_cnt), 64'd0);

        // Three busy registers, then asynchronous reset mid-cycle
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            bus.iss_valid = 1'b1; bus.iss_addr = AW'(r);
        end
        @(negedge clk);
        idle_wb();
        set_ra(5'd1, 5'd3);
        #1;
        chk("pre_rst_cnt", 64'(bus.busy_cnt), 64'd3);
        chk("pre_rst_rbusy", 64'(bus.rbusy), 64'b11);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("async_rst_rbusy", 64'(bus.rbusy), 64'b00);
        chk("async_rst_rdata", 64'(bus.rdata), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ra(5'd5, 5'd1);
        #1;
        chk("post_rst_rbusy", 64'(bus.rbusy), 64'b00);
        chk("post_rst_cnt", 64'(bus.busy_cnt), 64'd0);
`ifdef REGFILE_CLEAR_EN
        chk("post_rst_r5", 64'(bus.rdata[31:0]), 64'h0);
`else
        chk("post_rst_r5", 64'(bus.rdata[31:0]), 64'hDEADBEEF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
